// File: rtl/score_entry_if.sv
// Bus between the score-entry front end and whoever drives the raw inputs /
// consumes the clean scorein/submit pair.
interface score_entry_if;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] scorein;
    logic       submit;
    logic       err;
    logic [2:0] cnt;

    // Driver of raw switches/button, consumer of the cleaned outputs
    modport master (
        output sw,
        output btn,
        input  scorein,
        input  submit,
        input  err,
        input  cnt
    );

    // The score_entry block itself
    modport slave (
        input  sw,
        input  btn,
        output scorein,
        output submit,
        output err,
        output cnt
    );
endinterface

// File: rtl/score_entry.sv
// score_entry: synchronises and debounces the submit button, range-checks
// the score switches, latches the accepted score and issues one fixed-length
// submit pulse per debounced press. Also mirrors the downstream judge count.
module score_entry #(
    parameter int DEBOUNCE  = 50000,
    parameter int PULSE_LEN = 4,
    parameter int MAX_SCORE = 10
) (
    input logic          clk,
    input logic          rst,
    score_entry_if.slave bus
);

    localparam int DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam int PW   = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [3:0] MAX4 = 4'(MAX_SCORE);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PULSE    = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    logic            btn_m, btn_s;
    logic [3:0]      sw_m, sw_s;
    logic            btn_db, btn_db_q;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic [1:0]      state;
    logic [PW-1:0]   p_cnt;
    logic [3:0]      scorein_r;
    logic            submit_r;
    logic            err_r;
    logic [2:0]      cnt_r;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= bus.btn;
            btn_s <= btn_m;
            sw_m  <= bus.sw;
            sw_s  <= sw_m;
        end
    end

    // Debounce: the level changes once btn_s has disagreed with it for
    // DEBOUNCE-1 consecutive edges (DEBOUNCE cycles counting the first
    // synchronised cycle); any return to agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE - 2)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    // Press handling FSM: accept/reject/clear, pulse generation, release wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            p_cnt     <= '0;
            scorein_r <= '0;
            submit_r  <= 1'b0;
            err_r     <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        if (cnt_r == 3'd7) begin
                            cnt_r    <= '0;
                            err_r    <= 1'b0;
                            p_cnt    <= '0;
                            submit_r <= 1'b1;
                            state    <= PULSE;
                        end else if (sw_s <= MAX4) begin
                            scorein_r <= sw_s;
                            cnt_r     <= cnt_r + 3'd1;
                            err_r     <= 1'b0;
                            p_cnt     <= '0;
                            submit_r  <= 1'b1;
                            state     <= PULSE;
                        end else begin
                            err_r <= 1'b1;
                            state <= WAIT_REL;
                        end
                    end
                end
                PULSE: begin
                    if (p_cnt == PW'(PULSE_LEN - 1)) begin
                        submit_r <= 1'b0;
                        state    <= WAIT_REL;
                    end else begin
                        p_cnt <= p_cnt + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!btn_db) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.scorein = scorein_r;
    assign bus.submit  = submit_r;
    assign bus.err     = err_r;
    assign bus.cnt     = cnt_r;

endmodule

// File: tb/tb_score_entry.sv
// Bench for score_entry: directed scenarios plus randomised button/switch
// activity, checked every cycle against a transaction-level model.
module tb_score_entry;

    localparam int DB   = 4;
    localparam int PL   = 3;
    localparam int MAXS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_entry_if bus ();

    score_entry #(
        .DEBOUNCE (DB),
        .PULSE_LEN(PL),
        .MAX_SCORE(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Behavioural model state
    int b1, b2, s1, s2;          // synchroniser pipeline
    int db, db_prev, run;        // debounced level and disagreement run length
    int pulse_left, waiting;     // remaining submit cycles, waiting for release
    int m_score, m_err, m_cnt;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        b1 = 0; b2 = 0; s1 = 0; s2 = 0;
        db = 0; db_prev = 0; run = 0;
        pulse_left = 0; waiting = 0;
        m_score = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int press;
        int nb1, nb2, ns1, ns2;
        press = (db == 1 && db_prev == 0) ? 1 : 0;
        // Press handling based on pre-edge values
        if (pulse_left > 0) begin
            pulse_left--;
            if (pulse_left == 0) waiting = 1;
        end else if (waiting != 0) begin
            if (db == 0) waiting = 0;
        end else if (press != 0) begin
            if (m_cnt == 7) begin
                m_cnt = 0; m_err = 0; pulse_left = PL;
            end else if (s2 <= MAXS) begin
                m_score = s2; m_cnt = m_cnt + 1; m_err = 0; pulse_left = PL;
            end else begin
                m_err = 1; waiting = 1;
            end
        end
        // Debounced level follows btn_s after DB-1 consecutive disagreeing edges
        db_prev = db;
        if (b2 == db) run = 0;
        else begin
            run++;
            if (run == DB - 1) begin
                db = b2;
                run = 0;
            end
        end
        nb1 = int'(bus.btn); nb2 = b1; ns1 = int'(bus.sw); ns2 = s1;
        b1 = nb1; b2 = nb2; s1 = ns1; s2 = ns2;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, plus submit pulse counting
    initial begin
        int prev_sub;
        prev_sub = 0;
        forever begin
            @(negedge clk);
            check("scorein", int'(bus.scorein), m_score);
            check("submit", int'(bus.submit), (pulse_left > 0) ? 1 : 0);
            check("err", int'(bus.err), m_err);
            check("cnt", int'(bus.cnt), m_cnt);
            if (bus.submit && prev_sub == 0) pulses++;
            prev_sub = int'(bus.submit);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_hold(input int v, input int hold);
        @(negedge clk);
        bus.sw = 4'(v);
        @(negedge clk);
        bus.btn = 1'b1;
        repeat (hold) @(negedge clk);
        bus.btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int lat, k, p0;
        bus.sw  = '0;
        bus.btn = 1'b0;
        #1;
        check("reset_scorein", int'(bus.scorein), 0);
        check("reset_submit", int'(bus.submit), 0);
        check("reset_cnt", int'(bus.cnt), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clean press: submit rises on the 6th edge after btn is applied
        // (2 sync, DB-1 debounce, 1 FSM), stays high PL cycles
        @(negedge clk);
        bus.sw = 4'd7;
        repeat (2) @(negedge clk);
        p0 = pulses;
        bus.btn = 1'b1;
        lat = 0;
        while (!bus.submit && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("clean_latency", lat, 6);
        k = 0;
        while (bus.submit && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("clean_width", k, 3);
        repeat (12) @(negedge clk);
        bus.btn = 1'b0;
        repeat (12) @(negedge clk);
        check("clean_pulses", pulses - p0, 1);
        check("clean_scorein", int'(bus.scorein), 7);
        check("clean_cnt", int'(bus.cnt), 1);
        check("clean_err", int'(bus.err), 0);

        // Bounce then steady high
        p0 = pulses;
        bus.sw = 4'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.btn = (i % 2 == 0);
        end
        press_hold(2, 20);
        check("bounce_pulses", pulses - p0, 1);
        check("bounce_scorein", int'(bus.scorein), 2);
        check("bounce_cnt", int'(bus.cnt), 2);

        // Out of range then recovery
        p0 = pulses;
        press_hold(12, 20);
        check("oor_pulses", pulses - p0, 0);
        check("oor_err", int'(bus.err), 1);
        check("oor_scorein", int'(bus.scorein), 2);
        check("oor_cnt", int'(bus.cnt), 2);
        p0 = pulses;
        press_hold(9, 20);
        check("rec_pulses", pulses - p0, 1);
        check("rec_err", int'(bus.err), 0);
        check("rec_scorein", int'(bus.scorein), 9);
        check("rec_cnt", int'(bus.cnt), 3);

        // Count wrap: seven valid presses, then a clear press with sw=15
        do_reset();
        for (int i = 1; i <= 7; i++) press_hold(i, 10);
        check("wrap_cnt7", int'(bus.cnt), 7);
        p0 = pulses;
        press_hold(15, 10);
        check("wrap_pulses", pulses - p0, 1);
        check("wrap_err", int'(bus.err), 0);
        check("wrap_scorein", int'(bus.scorein), 7);
        check("wrap_cnt", int'(bus.cnt), 0);

        // Held button with sw change mid-pulse
        p0 = pulses;
        @(negedge clk);
        bus.sw = 4'd3;
        repeat (2) @(negedge clk);
        bus.btn = 1'b1;
        k = 0;
        while (!bus.submit && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("held_seen", int'(bus.submit), 1);
        bus.sw = 4'd8;
        repeat (100 - k) @(negedge clk);
        bus.btn = 1'b0;
        repeat (12) @(negedge clk);
        check("held_pulses", pulses - p0, 1);
        check("held_scorein", int'(bus.scorein), 3);

        // Reset during the 2nd submit cycle
        @(negedge clk);
        bus.sw = 4'd5;
        repeat (2) @(negedge clk);
        bus.btn = 1'b1;
        k = 0;
        while (!bus.submit && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_seen", int'(bus.submit), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.btn = 1'b0;
        #1;
        check("rstmid_submit", int'(bus.submit), 0);
        check("rstmid_cnt", int'(bus.cnt), 0);
        check("rstmid_scorein", int'(bus.scorein), 0);
        check("rstmid_err", int'(bus.err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Randomised bouncy presses, occasional asynchronous reset
        for (int it = 0; it < 250; it++) begin
            @(negedge clk);
            bus.sw = 4'($urandom_range(0, 15));
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                @(negedge clk);
                bus.btn = ~bus.btn;
            end
            @(negedge clk);
            bus.btn = 1'b1;
            repeat ($urandom_range(1, 14)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.sw = 4'($urandom_range(0, 15));
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                @(negedge clk);
                bus.btn = ~bus.btn;
            end
            @(negedge clk);
            bus.btn = 1'b0;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #5 rst = 1'b0;
            end
        end
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
